// File: rtl/sha3_result_pkg.sv
// Shared types and word-select constants for the SHA-3 result queue.
// SHA3_RESULT_QUEUE_STAMP_EN adds a scan-count stamp to every stored result.
package sha3_result_pkg;

    localparam int unsigned HASH_LANES = 25;
    localparam int unsigned LANE_W     = 64;
    localparam int unsigned NONCE_W    = 32;
    localparam int unsigned STAMP_W    = 32;
    localparam int unsigned SEL_W      = 5;

    localparam logic [SEL_W-1:0] RD_NONCE = 5'd25;
    localparam logic [SEL_W-1:0] RD_STAMP = 5'd26;

    typedef struct packed {
        logic [NONCE_W-1:0]                    nonce;
        logic [HASH_LANES-1:0][LANE_W-1:0]     hash;
`ifdef SHA3_RESULT_QUEUE_STAMP_EN
        logic [STAMP_W-1:0]                    stamp;
`endif
    } result_t;

    // Selects one 64-bit word of a stored result; unmapped selects read zero.
    function automatic logic [LANE_W-1:0] result_word(result_t r, logic [SEL_W-1:0] sel);
        logic [LANE_W-1:0] w;
        w = '0;
        if (sel < SEL_W'(HASH_LANES)) begin
            w = r.hash[sel];
        end else if (sel == RD_NONCE) begin
            w = LANE_W'(r.nonce);
`ifdef SHA3_RESULT_QUEUE_STAMP_EN
        end else if (sel == RD_STAMP) begin
            w = LANE_W'(r.stamp);
`endif
        end
        return w;
    endfunction

endpackage

// File: rtl/sha3_result_store.sv
// DEPTH-entry result storage: one write port and one registered word-select read port.
module sha3_result_store
    import sha3_result_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  result_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    input  logic [SEL_W-1:0]           rd_word,
    input  logic                       head_valid,
    output logic [LANE_W-1:0]          rd_data
);

    result_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head word is zeroed whenever the queue holds nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (head_valid) begin
            rd_data <= result_word(mem[raddr], rd_word);
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/sha3_result_queue.sv
// Result FIFO between the packed-pipeline scanner and the register front end.
// Optional SHA3_RESULT_QUEUE_STAMP_EN stores scan_count alongside each result.
module sha3_result_queue
    import sha3_result_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DROP_W = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               capture,
    input  logic [NONCE_W-1:0]                 nonce,
    input  logic [HASH_LANES-1:0][LANE_W-1:0]  hash,
    input  logic [STAMP_W-1:0]                 scan_count,
    input  logic                               pop,
    input  logic                               clear_flags,
    input  logic [SEL_W-1:0]                   rd_word,
    output logic [LANE_W-1:0]                  rd_data,
    output logic                               empty,
    output logic                               full,
    output logic [$clog2(DEPTH):0]             level,
    output logic                               overflow,
    output logic [DROP_W-1:0]                  drop_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_next;
    logic             do_push;
    logic             do_pop;
    logic             drop;
    result_t          wdata;

    // A pop on a full queue frees the slot the same-cycle capture lands in.
    always_comb begin
        do_pop  = pop && (level != '0);
        do_push = capture && ((level != LVL_W'(DEPTH)) || do_pop);
        drop    = capture && !do_push;
        level_next = level;
        if (do_push && !do_pop) begin
            level_next = level + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_next = level - LVL_W'(1);
        end
    end

    always_comb begin
        wdata       = '0;
        wdata.nonce = nonce;
        wdata.hash  = hash;
`ifdef SHA3_RESULT_QUEUE_STAMP_EN
        wdata.stamp = scan_count;
`endif
    end

`ifndef SHA3_RESULT_QUEUE_STAMP_EN
    logic unused_scan_count;
    assign unused_scan_count = ^scan_count;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_next;
            empty <= (level_next == '0);
            full  <= (level_next == LVL_W'(DEPTH));
        end
    end

    // A drop in the same cycle as clear_flags restarts the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (clear_flags) begin
                drop_count <= DROP_W'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + DROP_W'(1);
            end
        end else if (clear_flags) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    sha3_result_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .we         (do_push && !rst),
        .waddr      (wr_ptr),
        .wdata      (wdata),
        .raddr      (rd_ptr),
        .rd_word    (rd_word),
        .head_valid (!empty),
        .rd_data    (rd_data)
    );

endmodule

// File: tb/tb_sha3_result_queue.sv
// Directed self-checking bench for sha3_result_queue (DEPTH 4, DROP_W 2).
module tb_sha3_result_queue;
    import sha3_result_pkg::*;

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               capture;
    logic [NONCE_W-1:0]                 nonce;
    logic [HASH_LANES-1:0][LANE_W-1:0]  hash;
    logic [STAMP_W-1:0]                 scan_count;
    logic                               pop;
    logic                               clear_flags;
    logic [SEL_W-1:0]                   rd_word;
    logic [LANE_W-1:0]                  rd_data;
    logic                               empty;
    logic                               full;
    logic [2:0]                         level;
    logic                               overflow;
    logic [1:0]                         drop_count;

    int checks = 0;
    int errors = 0;
    logic [63:0] rd;

    always #5 clk = ~clk;

    sha3_result_queue #(
        .DEPTH  (4),
        .DROP_W (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .nonce       (nonce),
        .hash        (hash),
        .scan_count  (scan_count),
        .pop         (pop),
        .clear_flags (clear_flags),
        .rd_word     (rd_word),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .overflow    (overflow),
        .drop_count  (drop_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers nonce n with lanes {salt, lane index}.
    task automatic set_result(input logic [31:0] n, input logic [31:0] salt);
        nonce = n;
        for (int i = 0; i < 25; i++) hash[i] = {salt, 32'(i)};
    endtask

    task automatic read_word(input logic [4:0] sel, output logic [63:0] data);
        rd_word = sel;
        step();
        data = rd_data;
    endtask

    task automatic check_flags(input string tag, input int lvl, input logic ovf, input int drops);
        check_eq({tag, "_level"}, 64'(level), 64'(lvl));
        check_eq({tag, "_empty"}, 64'(empty), 64'(lvl == 0));
        check_eq({tag, "_full"},  64'(full),  64'(lvl == 4));
        check_eq({tag, "_ovf"},   64'(overflow), 64'(ovf));
        check_eq({tag, "_drops"}, 64'(drop_count), 64'(drops));
    endtask

    task automatic push_one(input logic [31:0] n, input logic [31:0] salt);
        set_result(n, salt);
        capture = 1'b1;
        step();
        capture = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [31:0] n, input logic [31:0] salt);
        read_word(RD_NONCE, rd);
        check_eq({tag, "_nonce"}, rd, 64'(n));
        read_word(5'd3, rd);
        check_eq({tag, "_lane3"}, rd, {salt, 32'd3});
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; capture = 1'b0; pop = 1'b0; clear_flags = 1'b0;
        rd_word = '0; scan_count = '0;
        set_result(32'h0, 32'h0);
        step(); step();
        rst = 1'b0;
        check_flags("reset", 0, 1'b0, 0);
        check_eq("reset_rd_data", rd_data, 64'h0);

        // Single push, word reads, pop
        scan_count = 32'h0000_ABCD;
        push_one(32'h1234_5678, 32'h0);
        scan_count = 32'h0;
        check_flags("push1", 1, 1'b0, 0);
        read_word(RD_NONCE, rd);
        check_eq("push1_nonce", rd, 64'h1234_5678);
        read_word(5'd7, rd);
        check_eq("push1_lane7", rd, 64'd7);
        read_word(5'd24, rd);
        check_eq("push1_lane24", rd, 64'd24);
        read_word(5'd30, rd);
        check_eq("push1_unmapped", rd, 64'h0);
        read_word(RD_STAMP, rd);
`ifdef SHA3_RESULT_QUEUE_STAMP_EN
        check_eq("push1_stamp", rd, 64'h0000_ABCD);
`else
        check_eq("push1_stamp", rd, 64'h0);
`endif
        pop = 1'b1; step(); pop = 1'b0;
        check_flags("pop1", 0, 1'b0, 0);
        read_word(RD_NONCE, rd);
        check_eq("empty_rd_data", rd, 64'h0);

        // Five back-to-back captures into a 4-deep queue
        capture = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_result(32'(i), 32'hA5);
            step();
        end
        capture = 1'b0;
        check_flags("burst", 4, 1'b1, 1);
        for (int i = 0; i < 4; i++) pop_expect($sformatf("burst_pop%0d", i), 32'(i), 32'hA5);
        check_flags("burst_drained", 0, 1'b1, 1);

        // Full queue with capture and pop in the same cycle
        clear_flags = 1'b1; step(); clear_flags = 1'b0;
        check_flags("clear", 0, 1'b0, 0);
        for (int i = 10; i < 14; i++) push_one(32'(i), 32'h77);
        set_result(32'd14, 32'h77);
        capture = 1'b1; pop = 1'b1;
        step();
        capture = 1'b0; pop = 1'b0;
        check_flags("full_pushpop", 4, 1'b0, 0);
        for (int i = 11; i < 15; i++) pop_expect($sformatf("fpp_pop%0d", i), 32'(i), 32'h77);

        // Pop on empty plus capture
        set_result(32'h55, 32'h33);
        capture = 1'b1; pop = 1'b1;
        step();
        capture = 1'b0; pop = 1'b0;
        check_flags("empty_pushpop", 1, 1'b0, 0);
        read_word(5'd0, rd);
        check_eq("empty_pushpop_lane0", rd, {32'h33, 32'd0});
        pop_expect("empty_pushpop_pop", 32'h55, 32'h33);

        // Drop counter saturation and clear_flags racing a drop
        for (int i = 20; i < 24; i++) push_one(32'(i), 32'h11);
        capture = 1'b1;
        for (int i = 30; i < 36; i++) begin
            set_result(32'(i), 32'h11);
            step();
        end
        check_flags("saturate", 4, 1'b1, 3);
        clear_flags = 1'b1;
        step();
        capture = 1'b0;
        check_flags("clear_vs_drop", 4, 1'b1, 1);
        step();
        clear_flags = 1'b0;
        check_flags("clear_alone", 4, 1'b0, 0);
        read_word(RD_NONCE, rd);
        check_eq("full_head", rd, 64'd20);

        // Reset while full, capture in the reset cycle is ignored
        rst = 1'b1; capture = 1'b1;
        step();
        rst = 1'b0; capture = 1'b0;
        check_flags("midreset", 0, 1'b0, 0);
        check_eq("midreset_rd_data", rd_data, 64'h0);
        read_word(RD_NONCE, rd);
        check_eq("midreset_after", rd, 64'h0);
        check_eq("midreset_level", 64'(level), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha3_result_queue.md
# sha3_result_queue

Buffers nonce/hash results produced by the packed-pipeline scanner until the AXI register front end reads them. Sits directly downstream of the scanner: consumes its capture strobe, nonce, 25-word hash and scan counter, and presents a FIFO head that software reads word by word and then pops. Drops are counted and flagged rather than back-pressuring the scanner, which has no stall input.

## Interface
- DEPTH, 4: number of result entries; power of two, 2..16.
- DROP_W, 16: width of the saturating drop counter.
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- capture  in  1  one result offered this cycle; connect to scanner ocapture.
- nonce  in  32  nonce of the offered result.
- hash  in  64 x 25  offered hash lanes, index 0..24.
- scan_count  in  32  scanner scan counter, sampled only with SHA3_RESULT_QUEUE_STAMP_EN.
- pop  in  1  discard the head entry.
- clear_flags  in  1  clear overflow and drop_count.
- rd_word  in  5  head word select: 0..24 hash lane, 25 nonce, 26 stamp, other values read 0.
- rd_data  out  64  registered head word selected by rd_word.
- empty  out  1  no entries stored.
- full  out  1  DEPTH entries stored.
- level  out  $clog2(DEPTH)+1  entries stored.
- overflow  out  1  sticky: at least one capture dropped.
- drop_count  out  DROP_W  saturating count of dropped captures.

## Operation
- Circular buffer, write pointer, read pointer, level counter; pointers wrap modulo DEPTH.
- Push: capture high and (not full, or pop accepted the same cycle) -> store {nonce, hash, stamp} at write pointer, advance it.
- Every cycle capture is high is a distinct result; no edge detection.
- Pop: pop high and not empty -> advance read pointer. Pop on empty ignored, no state change.
- Simultaneous push and pop: both occur, level unchanged; when full, the freed slot accepts the push (no drop).
- Simultaneous push and pop when empty: push occurs, pop ignored, level becomes 1.
- Drop: capture high, full, no pop -> entry discarded, overflow set, drop_count += 1 saturating at all-ones.
- clear_flags and a drop in the same cycle: drop wins; overflow = 1, drop_count = 1.
- rd_data reflects head entry; when empty, rd_data = 0.
- Reset mid-operation discards all entries immediately; capture in the reset cycle is ignored.

## Timing
- Reset values: empty = 1, full = 0, level = 0, overflow = 0, drop_count = 0, rd_data = 0.
- Push at edge N: empty/level/full update at edge N; entry readable with rd_data valid after edge N+1.
- rd_data latency: one cycle from rd_word (and from head change).
- Pop at edge N: next head visible on rd_data after edge N+1.
- No combinational path from inputs to any output.

## Configuration
- SHA3_RESULT_QUEUE_STAMP_EN defined: each entry also stores scan_count sampled at push; rd_word 26 returns it zero-extended to 64 bits.
- Undefined: stamp storage absent; rd_word 26 returns 0; scan_count unused.

## Structure
- Package sha3_result_pkg: HASH_LANES = 25, RD_NONCE = 25, RD_STAMP = 26, typedef result_t struct {nonce, hash[25], stamp under the macro}.
- One sub-module: sha3_result_store, the DEPTH x result_t storage array with one write port and one registered word-select read port; control (pointers, level, flags) stays in the top.

## Test plan
- Reset, push one result (nonce 0x12345678, hash[i] = i) -> level 1; rd_word 25 gives 0x12345678, rd_word 7 gives 7; pop -> empty after edge.
- Push 5 captures back to back with DEPTH 4 -> first 4 stored in order, overflow = 1, drop_count = 1; pops return nonces 0..3.
- Full queue, capture and pop same cycle -> no drop, level stays 4, new nonce becomes the last entry.
- Pop on empty plus capture same cycle -> level 1, entry intact.
- DROP_W = 2, 6 drops -> drop_count saturates at 3; clear_flags with a drop same cycle -> overflow = 1, drop_count = 1.
- With SHA3_RESULT_QUEUE_STAMP_EN, scan_count = 0xABCD at push -> rd_word 26 gives 0xABCD; without the macro -> 0. Reset asserted while full -> empty next cycle, rd_data = 0.
